neo_io_ctrl: RTL
================

NEO_IO_CTRL -- requirements
Module: neo_io_ctrl

Interface
REQ-001 The module SHALL have a parameter NSLOTS, default 6, range 2..8, giving the number of cartridge slots decoded.
REQ-002 The module SHALL have a parameter LED_CH, default 3, range 1..8, giving the number of LED latch outputs.
REQ-003 The module SHALL have a parameter RTC_DIV, default 24, minimum 2, giving clocks per RTC serial phase.
REQ-004 The module SHALL have a parameter DEBOUNCE, default 4, minimum 1, giving the number of stable clocks needed to accept a new input level.
REQ-005 The module SHALL have these ports, one per line as name, direction, width, meaning:
CLK_24M  in  1  sole clock, rising edge.
nRESET  in  1  asynchronous, active-low reset.
nDIPRD0 / nDIPRD1  in  1  read strobes for DIPSW/SYSTYPE and STATUS_A, active low.
nBITWD0  in  1  write strobe, active low, asynchronous to CLK_24M.
M68K_ADDR  in  [7:4]  address bits.
M68K_DATA  inout  8  data bus.
DIPSW  in  8  DIP switches.
SYSTEMB, TEST, SERVICE, TYPE_A, TYPE_B, RTC_DOUT, RTC_TP  in  1 each  system and board inputs.
COINS  in  4  coin inputs.
nSLOT  out  NSLOTS  one-hot slot select, active low.
SLOT_SEL  out  3  encoded slot number.
LED_LATCH  out  LED_CH  LED latch lines.
LED_DATA  out  8  LED data.
RTC_DIN, RTC_CLK, RTC_STROBE  out  1 each  uPD4990 interface.

Function
REQ-006 nBITWD0 SHALL be synchronised by 2 flops; a synchronised falling edge SHALL commit one write using M68K_ADDR/M68K_DATA sampled on that cycle, 3 clocks after the pin falls.
REQ-007 Commit decode on M68K_ADDR[6:4]: 010 -> SLOTS<=D[2:0]; 011 -> LED_LATCH<=D[LED_CH+2:3] (bits above D7 read 0); 100 -> LED_DATA<=D; 101 -> RTCCTRL<=D[2:0]; 110 -> RTC command start with D[3:0]; other codes ignored.
REQ-008 SERVICE, TEST and COINS[3:0] SHALL each be debounced: the filtered value updates only after the raw input has differed from it for DEBOUNCE consecutive clocks, and any mismatch break restarts the count.
REQ-009 M68K_DATA SHALL be driven only while a read strobe is low; with both strobes high it SHALL be high-Z.
REQ-010 nDIPRD0 low with ADDR[7]=1 SHALL drive {TEST_f, TYPE_A, RTC_BUSY, 5'b0}; with ADDR[7]=0 it SHALL drive DIPSW.
REQ-011 nDIPRD1 low SHALL drive {RTC_DOUT, RTC_TP, TYPE_B, COINS_f[3:2], SERVICE_f, COINS_f[1:0]}.
REQ-012 If both read strobes are low, nDIPRD0 data SHALL take priority.
REQ-013 SLOT_SEL SHALL be SYSTEMB ? SLOTS : 0.
REQ-014 nSLOT bit k SHALL be 0 iff SYSTEMB=1 and SLOTS==k; if SLOTS>=NSLOTS, all bits SHALL be 1.
REQ-015 The RTC engine states SHALL be IDLE, LO, HI, STRB, each non-IDLE state lasting RTC_DIV clocks.
REQ-016 A start command in IDLE SHALL move to LO with bit index 0 and RTC_BUSY=1.
REQ-017 In LO the outputs SHALL be RTC_CLK=0 and RTC_DIN=cmd[idx]; in HI, RTC_CLK=1 with RTC_DIN held.
REQ-018 HI SHALL go to LO with idx+1 when idx<3, else to STRB.
REQ-019 STRB SHALL drive RTC_STROBE=1, RTC_CLK=0 and RTC_DIN=0, then return to IDLE.
REQ-020 A command sequence SHALL last exactly 9*RTC_DIV clocks from the commit to IDLE.
REQ-021 In IDLE the RTC pins SHALL equal RTCCTRL {STROBE, CLK, DIN}; while busy the engine SHALL drive them.
REQ-022 While busy, writes to 101 and 110 SHALL be ignored, and no state SHALL change.
REQ-023 The 3-bit SLOTS field SHALL wrap naturally, with no saturation.

Reset
REQ-024 nRESET low SHALL immediately clear SLOTS, LED_LATCH, LED_DATA, RTCCTRL and the engine (IDLE, RTC_BUSY=0); all RTC outputs SHALL be 0.
REQ-025 Debounced inputs SHALL reset to 1 with counters at 0, and the sync flops SHALL reset to 1.
REQ-026 Reset asserted mid-sequence SHALL abort the sequence with no strobe pulse emitted.

Verification
REQ-027 Write 0x03 to addr 010 with SYSTEMB=1, NSLOTS=6 -> nSLOT=6'b110111, SLOT_SEL=3; then write 0x07 -> nSLOT=6'b111111, SLOT_SEL=7; then SYSTEMB=0 -> SLOT_SEL=0.
REQ-028 Write 0x0A to addr 110, RTC_DIV=2 -> RTC_DIN sequence 0,1,0,1, four RTC_CLK pulses, a 2-clock STROBE, and BUSY high for 18 clocks; a 101 write mid-sequence is ignored.
REQ-029 Toggle COINS[0] low for DEBOUNCE-1 clocks then high -> STATUS_A bit0 stays 1; hold low for DEBOUNCE clocks -> bit0 reads 0.
REQ-030 Both read strobes low with ADDR[7]=0, DIPSW=0xA5 -> bus=0xA5; both strobes high -> Z.
REQ-031 Write 0xFF to addr 100, then 0x38 to addr 011 (LED_CH=3) -> LED_DATA=0xFF, LED_LATCH=3'b111; pulse nRESET mid RTC sequence -> all outputs 0, BUSY=0.

Source files
------------

// File: rtl/neo_io_ctrl.sv
// neo_io_ctrl
// I/O controller for a cartridge-based arcade board. It decodes CPU writes
// into slot select, LED latch and RTC control registers. It serves the
// DIP switch and STATUS_A read ports. It also runs a small serial engine
// that clocks 4-bit commands into a uPD4990 real-time clock.
//
// Ports
//   CLK_24M            sole clock, rising edge
//   nRESET             asynchronous active-low reset
//   nDIPRD0, nDIPRD1   active-low read strobes (DIPSW/SYSTYPE, STATUS_A)
//   nBITWD0            active-low write strobe, asynchronous to CLK_24M
//   M68K_ADDR[7:4]     CPU address bits
//   M68K_DATA[7:0]     bidirectional CPU data bus
//   DIPSW[7:0]         DIP switches
//   SYSTEMB, TYPE_A, TYPE_B, RTC_DOUT, RTC_TP   board status inputs
//   TEST, SERVICE, COINS[3:0]                   debounced front-panel inputs
//   nSLOT[NSLOTS-1:0]  one-hot slot select, active low
//   SLOT_SEL[2:0]      encoded slot number
//   LED_LATCH          LED latch lines
//   LED_DATA[7:0]      LED data
//   RTC_DIN, RTC_CLK, RTC_STROBE                uPD4990 serial interface

module neo_io_ctrl #(
  parameter int NSLOTS   = 6,
  parameter int LED_CH   = 3,
  parameter int RTC_DIV  = 24,
  parameter int DEBOUNCE = 4
) (
  input  logic              CLK_24M,
  input  logic              nRESET,
  input  logic              nDIPRD0,
  input  logic              nDIPRD1,
  input  logic              nBITWD0,
  input  logic [7:4]        M68K_ADDR,
  inout  wire  [7:0]        M68K_DATA,
  input  logic [7:0]        DIPSW,
  input  logic              SYSTEMB,
  input  logic              TEST,
  input  logic              SERVICE,
  input  logic              TYPE_A,
  input  logic              TYPE_B,
  input  logic              RTC_DOUT,
  input  logic              RTC_TP,
  input  logic [3:0]        COINS,
  output logic [NSLOTS-1:0] nSLOT,
  output logic [2:0]        SLOT_SEL,
  output logic [LED_CH-1:0] LED_LATCH,
  output logic [7:0]        LED_DATA,
  output logic              RTC_DIN,
  output logic              RTC_CLK,
  output logic              RTC_STROBE
);

  localparam int DCW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE - 1);
  localparam int RCW = $clog2(RTC_DIV);
  localparam logic [RCW-1:0] DIV_LAST = RCW'(RTC_DIV - 1);

  typedef enum logic [1:0] {
    RTC_IDLE,
    RTC_LO,
    RTC_HI,
    RTC_STRB
  } rtc_state_t;

  // Write strobe synchroniser plus one extra stage for edge detection.
  logic wd_s1, wd_s2, wd_s3;
  logic commit;
  logic [2:0] wr_code;

  logic [2:0]        slots;
  logic [LED_CH-1:0] led_latch;
  logic [7:0]        led_data;
  logic [2:0]        rtcctrl;

  rtc_state_t     rtc_state, rtc_state_nx;
  logic [RCW-1:0] rtc_cnt, rtc_cnt_nx;
  logic [1:0]     rtc_idx, rtc_idx_nx;
  logic [3:0]     rtc_cmd, rtc_cmd_nx;
  logic           rtc_busy;
  logic           rtc_start;

  // Debounce channels: 0 SERVICE, 1 TEST, 2..5 COINS[0..3].
  logic [5:0]     deb_raw;
  logic [5:0]     deb_f;
  logic [DCW-1:0] deb_cnt [6];

  logic [7:0] rd_data;
  logic       rd_en;

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      wd_s1 <= 1'b1;
      wd_s2 <= 1'b1;
      wd_s3 <= 1'b1;
    end else begin
      wd_s1 <= nBITWD0;
      wd_s2 <= wd_s1;
      wd_s3 <= wd_s2;
    end
  end

  // One commit per synchronised falling edge; address and data are taken
  // on the commit cycle itself.
  assign commit  = wd_s3 & ~wd_s2;
  assign wr_code = M68K_ADDR[6:4];
  assign rtc_busy  = (rtc_state != RTC_IDLE);
  assign rtc_start = commit && (wr_code == 3'b110) && !rtc_busy;

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      slots     <= '0;
      led_latch <= '0;
      led_data  <= '0;
      rtcctrl   <= '0;
    end else if (commit) begin
      case (wr_code)
        3'b010: slots     <= M68K_DATA[2:0];
        // Latch bits come from D3 upward; anything past D7 reads as zero.
        3'b011: led_latch <= LED_CH'(M68K_DATA >> 3);
        3'b100: led_data  <= M68K_DATA;
        3'b101: if (!rtc_busy) rtcctrl <= M68K_DATA[2:0];
        default: ;
      endcase
    end
  end

  // A channel only takes a new level after DEBOUNCE consecutive clocks
  // of disagreement; any agreeing clock restarts the count.
  assign deb_raw = {COINS, TEST, SERVICE};

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      deb_f <= '1;
      for (int i = 0; i < 6; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (deb_raw[i] != deb_f[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb_f[i]   <= deb_raw[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      rtc_state <= RTC_IDLE;
      rtc_cnt   <= '0;
      rtc_idx   <= '0;
      rtc_cmd   <= '0;
    end else begin
      rtc_state <= rtc_state_nx;
      rtc_cnt   <= rtc_cnt_nx;
      rtc_idx   <= rtc_idx_nx;
      rtc_cmd   <= rtc_cmd_nx;
    end
  end

  // Four LO/HI bit cells followed by one strobe phase. Each phase lasts
  // RTC_DIV clocks, so a command takes 9*RTC_DIV clocks in total.
  always_comb begin
    rtc_state_nx = rtc_state;
    rtc_cnt_nx   = rtc_cnt;
    rtc_idx_nx   = rtc_idx;
    rtc_cmd_nx   = rtc_cmd;
    RTC_STROBE   = 1'b0;
    RTC_CLK      = 1'b0;
    RTC_DIN      = 1'b0;

    case (rtc_state)
      RTC_IDLE: begin
        {RTC_STROBE, RTC_CLK, RTC_DIN} = rtcctrl;
        if (rtc_start) begin
          rtc_state_nx = RTC_LO;
          rtc_cnt_nx   = '0;
          rtc_idx_nx   = '0;
          rtc_cmd_nx   = M68K_DATA[3:0];
        end
      end
      RTC_LO: begin
        RTC_DIN = rtc_cmd[rtc_idx];
        if (rtc_cnt == DIV_LAST) begin
          rtc_state_nx = RTC_HI;
          rtc_cnt_nx   = '0;
        end else begin
          rtc_cnt_nx = rtc_cnt + 1'b1;
        end
      end
      RTC_HI: begin
        RTC_CLK = 1'b1;
        RTC_DIN = rtc_cmd[rtc_idx];
        if (rtc_cnt == DIV_LAST) begin
          rtc_cnt_nx = '0;
          if (rtc_idx != 2'd3) begin
            rtc_state_nx = RTC_LO;
            rtc_idx_nx   = rtc_idx + 1'b1;
          end else begin
            rtc_state_nx = RTC_STRB;
          end
        end else begin
          rtc_cnt_nx = rtc_cnt + 1'b1;
        end
      end
      RTC_STRB: begin
        RTC_STROBE = 1'b1;
        if (rtc_cnt == DIV_LAST) begin
          rtc_state_nx = RTC_IDLE;
          rtc_cnt_nx   = '0;
        end else begin
          rtc_cnt_nx = rtc_cnt + 1'b1;
        end
      end
      default: rtc_state_nx = RTC_IDLE;
    endcase
  end

  // nDIPRD0 wins when both strobes are low.
  always_comb begin
    rd_data = {RTC_DOUT, RTC_TP, TYPE_B, deb_f[5:4], deb_f[0], deb_f[3:2]};
    if (!nDIPRD0) begin
      if (M68K_ADDR[7]) rd_data = {deb_f[1], TYPE_A, rtc_busy, 5'b00000};
      else              rd_data = DIPSW;
    end
  end

  assign rd_en     = !nDIPRD0 || !nDIPRD1;
  assign M68K_DATA = rd_en ? rd_data : 8'hzz;

  assign SLOT_SEL  = SYSTEMB ? slots : 3'b000;
  assign LED_LATCH = led_latch;
  assign LED_DATA  = led_data;

  // Out-of-range slot numbers match no output, leaving all lines high.
  for (genvar k = 0; k < NSLOTS; k++) begin : g_slot
    assign nSLOT[k] = ~(SYSTEMB && (slots == 3'(k)));
  end

endmodule
